// File: rtl/pid_sweep_scheduler.sv
// Sweeps every motor's PID loop through one shared pipelined signed multiplier
// on each control tick and emits a deadbanded, saturated PWM command per motor.
module pid_sweep_scheduler #(
  parameter int NUM_MOTORS = 4,
  parameter int MSEL_W     = 2,
  parameter int MUL_LAT    = 2
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     tick,
  output logic [MSEL_W-1:0]        motor_sel,
  input  logic signed [31:0]       setpoint,
  input  logic signed [31:0]       state,
  input  logic signed [31:0]       Kp,
  input  logic signed [31:0]       Ki,
  input  logic signed [31:0]       Kd,
  input  logic signed [31:0]       PWMLimit,
  input  logic signed [31:0]       IntegralLimit,
  input  logic signed [31:0]       deadband,
  input  logic [NUM_MOTORS-1:0]    motor_enable,
  output logic signed [31:0]       mul_a,
  output logic signed [31:0]       mul_b,
  input  logic signed [63:0]       mul_p,
  output logic signed [31:0]       pwm_out,
  output logic [MSEL_W-1:0]        pwm_idx,
  output logic                     pwm_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int PH_W = $clog2(MUL_LAT + 5);
  localparam logic [PH_W-1:0]   PH_ACC_P = PH_W'(MUL_LAT + 1);
  localparam logic [PH_W-1:0]   PH_ACC_I = PH_W'(MUL_LAT + 2);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(MUL_LAT + 3);
  localparam logic [MSEL_W-1:0] LAST_M   = MSEL_W'(NUM_MOTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE_P, S_ISSUE_I, S_ISSUE_D, S_DRAIN, S_OUTPUT
  } fsm_e;

  fsm_e                     fsm_q, fsm_d;
  logic [PH_W-1:0]          phase_q, phase_d;
  logic [MSEL_W-1:0]        motor_sel_q, motor_sel_d;
  logic signed [65:0]       acc_q, acc_d;
  logic signed [31:0]       err_q, err_d, integ_q, integ_d, derr_q, derr_d;
  logic signed [31:0]       ki_q, ki_d, kd_q, kd_d, pwm_lim_q, pwm_lim_d, db_q, db_d;
  logic                     en_q, en_d;
  logic signed [31:0]       integral_q [NUM_MOTORS];
  logic signed [31:0]       integral_d [NUM_MOTORS];
  logic signed [31:0]       err_prev_q [NUM_MOTORS];
  logic signed [31:0]       err_prev_d [NUM_MOTORS];
  logic signed [31:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic signed [31:0]       pwm_out_q, pwm_out_d;
  logic [MSEL_W-1:0]        pwm_idx_q, pwm_idx_d;
  logic                     pwm_valid_q, pwm_valid_d, busy_q, busy_d, overrun_q, overrun_d;

  logic signed [31:0]       err_c, derr_c, integ_new_c, result_c;
  logic signed [32:0]       sum_c, il_c;
  logic signed [65:0]       p_ext_c, r_c, r_abs_c, lim_c, db_c;

  // Fetch-time arithmetic: error, clamped integral and derivative of the selected motor.
  always_comb begin
    err_c  = setpoint - state;
    derr_c = err_c - err_prev_q[motor_sel_q];
    sum_c  = $signed({integral_q[motor_sel_q][31], integral_q[motor_sel_q]})
           + $signed({err_c[31], err_c});
    il_c   = $signed({IntegralLimit[31], IntegralLimit});
    if (IntegralLimit <= 0)  integ_new_c = '0;
    else if (sum_c > il_c)   integ_new_c = IntegralLimit;
    else if (sum_c < -il_c)  integ_new_c = -IntegralLimit;
    else                     integ_new_c = sum_c[31:0];
  end

  // Final result uses the accumulator plus the D product arriving this cycle.
  always_comb begin
    p_ext_c = $signed({{2{mul_p[63]}}, mul_p});
    r_c     = acc_q + p_ext_c;
    r_abs_c = r_c[65] ? -r_c : r_c;
    lim_c   = $signed({{34{pwm_lim_q[31]}}, pwm_lim_q});
    db_c    = $signed({{34{db_q[31]}}, db_q});
    if (!en_q || (r_abs_c <= db_c) || (pwm_lim_q <= 0)) result_c = '0;
    else if (r_c > lim_c)                                result_c = pwm_lim_q;
    else if (r_c < -lim_c)                               result_c = -pwm_lim_q;
    else                                                 result_c = r_c[31:0];
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    fsm_d       = fsm_q;
    phase_d     = phase_q + PH_W'(1);
    motor_sel_d = motor_sel_q;
    acc_d       = acc_q;
    err_d       = err_q;
    integ_d     = integ_q;
    derr_d      = derr_q;
    ki_d        = ki_q;
    kd_d        = kd_q;
    pwm_lim_d   = pwm_lim_q;
    db_d        = db_q;
    en_d        = en_q;
    integral_d  = integral_q;
    err_prev_d  = err_prev_q;
    mul_a_d     = '0;
    mul_b_d     = '0;
    pwm_out_d   = pwm_out_q;
    pwm_idx_d   = pwm_idx_q;
    pwm_valid_d = 1'b0;
    overrun_d   = tick && (fsm_q != S_IDLE);

    case (fsm_q)
      S_IDLE: begin
        phase_d = '0;
        if (tick) begin
          fsm_d       = S_FETCH;
          motor_sel_d = '0;
        end
      end
      S_FETCH: begin
        en_d      = motor_enable[motor_sel_q];
        err_d     = err_c;
        integ_d   = integ_new_c;
        derr_d    = derr_c;
        ki_d      = Ki;
        kd_d      = Kd;
        pwm_lim_d = PWMLimit;
        db_d      = deadband;
        acc_d     = '0;
        integral_d[motor_sel_q] = motor_enable[motor_sel_q] ? integ_new_c : '0;
        err_prev_d[motor_sel_q] = motor_enable[motor_sel_q] ? err_c : '0;
        mul_a_d   = Kp;
        mul_b_d   = err_c;
        fsm_d     = S_ISSUE_P;
      end
      S_ISSUE_P: begin
        mul_a_d = ki_q;
        mul_b_d = integ_q;
        fsm_d   = S_ISSUE_I;
      end
      S_ISSUE_I: begin
        mul_a_d = kd_q;
        mul_b_d = derr_q;
        fsm_d   = S_ISSUE_D;
      end
      S_ISSUE_D: fsm_d = S_DRAIN;
      S_DRAIN: begin
        if (phase_q == PH_LAST) begin
          fsm_d       = S_OUTPUT;
          pwm_out_d   = result_c;
          pwm_idx_d   = motor_sel_q;
          pwm_valid_d = 1'b1;
        end
      end
      S_OUTPUT: begin
        phase_d = '0;
        if (motor_sel_q == LAST_M) begin
          fsm_d       = S_IDLE;
          motor_sel_d = '0;
        end else begin
          fsm_d       = S_FETCH;
          motor_sel_d = motor_sel_q + MSEL_W'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    // P and I products land here; the D product is folded straight into result_c.
    if ((phase_q == PH_ACC_P) || (phase_q == PH_ACC_I))
      acc_d = acc_q + p_ext_c;

    busy_d = (fsm_d != S_IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      fsm_q       <= S_IDLE;
      phase_q     <= '0;
      motor_sel_q <= '0;
      acc_q       <= '0;
      err_q       <= '0;
      integ_q     <= '0;
      derr_q      <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      pwm_lim_q   <= '0;
      db_q        <= '0;
      en_q        <= 1'b0;
      // NOTE: the per-motor history is architectural state, so it is flops with reset, not RAM.
      for (int i = 0; i < NUM_MOTORS; i++) begin
        integral_q[i] <= '0;
        err_prev_q[i] <= '0;
      end
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      pwm_out_q   <= '0;
      pwm_idx_q   <= '0;
      pwm_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      phase_q     <= phase_d;
      motor_sel_q <= motor_sel_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      integ_q     <= integ_d;
      derr_q      <= derr_d;
      ki_q        <= ki_d;
      kd_q        <= kd_d;
      pwm_lim_q   <= pwm_lim_d;
      db_q        <= db_d;
      en_q        <= en_d;
      integral_q  <= integral_d;
      err_prev_q  <= err_prev_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      pwm_out_q   <= pwm_out_d;
      pwm_idx_q   <= pwm_idx_d;
      pwm_valid_q <= pwm_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign motor_sel = motor_sel_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign pwm_out   = pwm_out_q;
  assign pwm_idx   = pwm_idx_q;
  assign pwm_valid = pwm_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule
